// File: rtl/sal_axi_traffic_gen_if.sv
// AXI4 bus between the traffic generator (master) and the memory controller (slave).
// Channels: AW (awid/awaddr/awlen/awsize/awburst/awvalid/awready),
//           W  (wdata/wstrb/wlast/wvalid/wready),
//           B  (bid/bresp/bvalid/bready),
//           AR (arid/araddr/arlen/arsize/arburst/arvalid/arready),
//           R  (rid/rdata/rresp/rlast/rvalid/rready).
interface sal_axi_traffic_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/sal_axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator, one outstanding transaction at a time.
// Ports: clk, rst_n (async active-low); start pulse with base_addr/num_txns sampled on it;
//        busy/done/pass/err_count status; axi = AXI4 master port (all outputs registered).
module sal_axi_traffic_gen #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned BURST_LEN    = 4,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_5A5A
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_txns,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  sal_axi_traffic_gen_if.master axi
);

  localparam int unsigned LANES  = DATA_WIDTH / 32;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0]  SIZE   = 3'($clog2(STRB_W));
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BURST_LEN * STRB_W);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t          state;
  logic [ADDR_WIDTH-1:0] base;
  logic [15:0]     txn_total;
  logic [15:0]     txn;
  logic [7:0]      beat;

  // Deterministic data for one beat: lane k = {txn, beat, k} ^ seed
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] t, input logic [7:0] b);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      p[k*32 +: 32] = {t, b, 8'(k)} ^ PATTERN_SEED;
    end
    return p;
  endfunction

  logic [DATA_WIDTH-1:0] exp_rdata_c;
  logic                  b_fire_c;
  logic                  r_fire_c;
  logic                  beat_bad_c;
  logic                  r_end_c;
  logic [7:0]            missing_c;
  logic [7:0]            err_inc_c;
  logic [16:0]           err_sum_c;
  logic [15:0]           err_next_c;
  logic                  last_txn_c;

  // Response checking and saturating error accumulation
  always_comb begin
    exp_rdata_c = pattern(txn, beat);
    b_fire_c    = axi.bready && axi.bvalid;
    r_fire_c    = axi.rready && axi.rvalid;
    beat_bad_c  = (axi.rdata != exp_rdata_c) || (axi.rresp != 2'b00) || (axi.rid != '0) ||
                  (axi.rlast != (beat == LAST_BEAT));
    r_end_c     = axi.rlast || (beat == LAST_BEAT);
    // an early rlast leaves the remaining beats unread; each one is an error
    missing_c   = (axi.rlast && (beat < LAST_BEAT)) ? (LAST_BEAT - beat) : 8'd0;
    err_inc_c   = 8'd0;
    if (b_fire_c) begin
      err_inc_c = 8'((axi.bresp != 2'b00) || (axi.bid != '0));
    end else if (r_fire_c) begin
      err_inc_c = 8'(beat_bad_c) + missing_c;
    end
    err_sum_c   = 17'(err_count) + 17'(err_inc_c);
    err_next_c  = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
    last_txn_c  = (txn + 16'd1) == txn_total;
  end

  // Control FSM; every AXI output is a register set on entry to its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      txn_total   <= '0;
      txn         <= '0;
      beat        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      axi.awid    <= '0;
      axi.awaddr  <= '0;
      axi.awlen   <= '0;
      axi.awsize  <= '0;
      axi.awburst <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wlast   <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arid    <= '0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arsize  <= '0;
      axi.arburst <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            base      <= base_addr;
            txn_total <= num_txns;
            txn       <= '0;
            err_count <= '0;
            if (num_txns == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state       <= WR_ADDR;
              busy        <= 1'b1;
              done        <= 1'b0;
              pass        <= 1'b0;
              axi.awid    <= '0;
              axi.awaddr  <= base_addr;
              axi.awlen   <= LAST_BEAT;
              axi.awsize  <= SIZE;
              axi.awburst <= 2'b01;
              axi.awvalid <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (axi.awready) begin
            state       <= WR_DATA;
            axi.awvalid <= 1'b0;
            beat        <= '0;
            axi.wdata   <= pattern(txn, 8'd0);
            axi.wstrb   <= '1;
            axi.wlast   <= (LAST_BEAT == 8'd0);
            axi.wvalid  <= 1'b1;
          end
        end
        WR_DATA: begin
          if (axi.wready) begin
            if (beat == LAST_BEAT) begin
              state      <= WR_RESP;
              axi.wvalid <= 1'b0;
              axi.wlast  <= 1'b0;
              axi.bready <= 1'b1;
            end else begin
              beat      <= beat + 8'd1;
              axi.wdata <= pattern(txn, beat + 8'd1);
              axi.wlast <= (beat + 8'd1) == LAST_BEAT;
            end
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            err_count  <= err_next_c;
            axi.bready <= 1'b0;
            if (last_txn_c) begin
              state       <= RD_ADDR;
              txn         <= '0;
              axi.arid    <= '0;
              axi.araddr  <= base;
              axi.arlen   <= LAST_BEAT;
              axi.arsize  <= SIZE;
              axi.arburst <= 2'b01;
              axi.arvalid <= 1'b1;
            end else begin
              state       <= WR_ADDR;
              txn         <= txn + 16'd1;
              axi.awaddr  <= axi.awaddr + STRIDE;
              axi.awvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            state       <= RD_DATA;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            beat        <= '0;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            err_count <= err_next_c;
            if (r_end_c) begin
              axi.rready <= 1'b0;
              if (last_txn_c) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next_c == 16'd0);
              end else begin
                state       <= RD_ADDR;
                txn         <= txn + 16'd1;
                axi.araddr  <= axi.araddr + STRIDE;
                axi.arvalid <= 1'b1;
              end
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sal_axi_traffic_gen.sv
// Directed bench for sal_axi_traffic_gen with a reactive memory slave on the AXI interface.
module tb_sal_axi_traffic_gen;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned IW = 4;
  localparam int unsigned BL = 4;
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_txns = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;

  sal_axi_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  sal_axi_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_LEN(BL), .PATTERN_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_txns(num_txns),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .axi(axi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // slave knobs
  int unsigned rdy_pct = 100;
  int bad_b_txn = -1, bad_r_txn = -1, bad_r_beat = -1, early_txn = -1, early_beat = -1;
  int stab_err = 0, proto_err = 0;

  logic [31:0]  aw_log[$];
  logic [31:0]  ar_log[$];
  logic [128:0] w_log[$];
  logic [127:0] mem [int unsigned];

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int t, input int b);
    logic [127:0] p;
    logic [15:0]  tt;
    logic [7:0]   bb;
    tt = 16'(t);
    bb = 8'(b);
    for (int k = 0; k < 4; k++) p[k*32 +: 32] = {tt, bb, 8'(k)} ^ SEED;
    return p;
  endfunction

  function automatic bit roll();
    return $urandom_range(99) < rdy_pct;
  endfunction

  // Memory slave: all of its outputs change on the falling edge only
  initial begin : slave
    bit b_pend, b_fire, r_act, r_fire, aw_h, w_h, ar_h;
    int wbeat, rbeat;
    logic [31:0]  wr_addr, rd_addr, aw_ha, ar_ha;
    logic [128:0] w_hd;
    logic [127:0] d;
    b_pend = 0; b_fire = 0; r_act = 0; r_fire = 0; aw_h = 0; w_h = 0; ar_h = 0;
    wbeat = 0; rbeat = 0; wr_addr = '0; rd_addr = '0; aw_ha = '0; ar_ha = '0; w_hd = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = '0; axi.bid = '0;
    axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rid = '0; axi.rlast = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = '0; axi.bid = '0;
        axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rid = '0; axi.rlast = 0;
        b_pend = 0; b_fire = 0; r_act = 0; r_fire = 0; aw_h = 0; w_h = 0; ar_h = 0; wbeat = 0;
      end else begin
        // a valid left waiting must still be up with the same payload
        if (aw_h && !(axi.awvalid && axi.awaddr == aw_ha)) stab_err++;
        if (w_h && !(axi.wvalid && {axi.wlast, axi.wdata} == w_hd)) stab_err++;
        if (ar_h && !(axi.arvalid && axi.araddr == ar_ha)) stab_err++;
        // retire handshakes taken on the last rising edge
        if (b_fire) begin axi.bvalid = 0; b_fire = 0; end
        if (r_fire) begin
          axi.rvalid = 0; r_fire = 0;
          if (axi.rlast) r_act = 0; else rbeat++;
        end
        if (b_pend && !axi.bvalid && roll()) begin
          axi.bvalid = 1; axi.bid = '0;
          axi.bresp = (aw_log.size() - 1 == bad_b_txn) ? 2'b10 : 2'b00;
          b_pend = 0;
        end
        if (r_act && !axi.rvalid && roll()) begin
          d = mem[(rd_addr >> 4) + 32'(rbeat)];
          if (ar_log.size() - 1 == bad_r_txn && rbeat == bad_r_beat) d[0] = ~d[0];
          axi.rvalid = 1; axi.rid = '0; axi.rresp = '0; axi.rdata = d;
          axi.rlast = (rbeat == BL - 1) || (ar_log.size() - 1 == early_txn && rbeat == early_beat);
        end
        axi.awready = roll(); axi.wready = roll(); axi.arready = roll();
        // handshakes that the coming rising edge will take
        if (axi.awvalid && axi.awready) begin
          aw_log.push_back(axi.awaddr); wr_addr = axi.awaddr; wbeat = 0;
          if (axi.awid != '0 || axi.awlen != 8'(BL - 1) || axi.awsize != 3'd4 || axi.awburst != 2'b01)
            proto_err++;
        end
        if (axi.wvalid && axi.wready) begin
          w_log.push_back({axi.wlast, axi.wdata});
          mem[(wr_addr >> 4) + 32'(wbeat)] = axi.wdata;
          if (axi.wstrb != '1) proto_err++;
          wbeat++;
          if (wbeat == BL) b_pend = 1;
        end
        if (axi.arvalid && axi.arready) begin
          ar_log.push_back(axi.araddr); rd_addr = axi.araddr; rbeat = 0; r_act = 1;
          if (axi.arid != '0 || axi.arlen != 8'(BL - 1) || axi.arsize != 3'd4 || axi.arburst != 2'b01)
            proto_err++;
        end
        b_fire = axi.bvalid && axi.bready;
        r_fire = axi.rvalid && axi.rready;
        aw_h = axi.awvalid && !axi.awready; aw_ha = axi.awaddr;
        w_h  = axi.wvalid && !axi.wready;   w_hd  = {axi.wlast, axi.wdata};
        ar_h = axi.arvalid && !axi.arready; ar_ha = axi.araddr;
      end
    end
  end

  task automatic clear_logs();
    aw_log.delete(); ar_log.delete(); w_log.delete();
    stab_err = 0; proto_err = 0;
    bad_b_txn = -1; bad_r_txn = -1; bad_r_beat = -1; early_txn = -1; early_beat = -1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge clk);
    base_addr = b; num_txns = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_wait", 160'(done), 160'(1));
  endtask

  task automatic check_run(input logic [31:0] b, input int n, input int e, input bit p);
    chk("aw_count", 160'(aw_log.size()), 160'(n));
    foreach (aw_log[i]) chk("aw_addr", 160'(aw_log[i]), 160'(b + 32'(i) * 32'd64));
    chk("w_count", 160'(w_log.size()), 160'(n * 4));
    foreach (w_log[i]) chk("w_beat", 160'(w_log[i]), 160'({(i % 4) == 3, pat(i / 4, i % 4)}));
    chk("ar_count", 160'(ar_log.size()), 160'(n));
    foreach (ar_log[i]) chk("ar_addr", 160'(ar_log[i]), 160'(b + 32'(i) * 32'd64));
    chk("status", 160'({busy, done, pass}), 160'({1'b0, 1'b1, p}));
    chk("err_count", 160'(err_count), 160'(e));
    chk("stable", 160'(stab_err), 160'(0));
    chk("fields", 160'(proto_err), 160'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_status", 160'({busy, done, pass, err_count}), 160'(0));
    chk("rst_valids", 160'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 160'(0));
    chk("rst_payload", 160'({axi.awaddr, axi.awlen, axi.wlast, axi.araddr}), 160'(0));
    rst_n = 1'b1;

    // zero-length run: done and pass one cycle after start, no bus traffic
    clear_logs();
    do_start(32'h5000, 16'd0);
    chk("n0_status", 160'({busy, done, pass, err_count}), 160'({1'b0, 1'b1, 1'b1, 16'd0}));
    repeat (5) @(negedge clk);
    chk("n0_traffic", 160'(aw_log.size() + ar_log.size() + w_log.size()), 160'(0));

    // ideal slave
    clear_logs(); rdy_pct = 100;
    do_start(32'h0000_1000, 16'd3);
    chk("ideal_busy", 160'({busy, done}), 160'({1'b1, 1'b0}));
    wait_done(5000);
    check_run(32'h1000, 3, 0, 1'b1);
    chk("ideal_aw2", 160'(aw_log.size() > 2 ? aw_log[2] : 32'h0), 160'(32'h1080));

    // 30% back-pressure
    clear_logs(); rdy_pct = 30;
    do_start(32'h0000_1000, 16'd3);
    wait_done(5000);
    check_run(32'h1000, 3, 0, 1'b1);

    // bad bresp on txn 0, flipped data bit on txn 1 beat 2
    clear_logs(); rdy_pct = 100;
    bad_b_txn = 0; bad_r_txn = 1; bad_r_beat = 2;
    do_start(32'h0000_1000, 16'd3);
    wait_done(5000);
    check_run(32'h1000, 3, 2, 1'b0);

    // early rlast on txn 0 beat 1: one wrong-rlast beat plus two missing
    clear_logs(); rdy_pct = 60;
    early_txn = 0; early_beat = 1;
    do_start(32'h0000_8000, 16'd3);
    wait_done(5000);
    check_run(32'h8000, 3, 3, 1'b0);

    // start while busy is ignored
    clear_logs(); rdy_pct = 100;
    do_start(32'h0000_3000, 16'd2);
    repeat (3) @(negedge clk);
    chk("busy_mid", 160'(busy), 160'(1));
    do_start(32'h0000_9000, 16'd5);
    wait_done(5000);
    check_run(32'h3000, 2, 0, 1'b1);

    // async reset while beat 2 of the first write burst is on the bus
    clear_logs(); rdy_pct = 100;
    do_start(32'h0000_2000, 16'd2);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (axi.wvalid && w_log.size() == 2) break;
    end
    chk("wr_beat2", 160'({axi.wvalid, axi.wdata}), 160'({1'b1, pat(0, 2)}));
    rst_n = 1'b0;
    #1;
    chk("async_valids", 160'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 160'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", 160'({busy, done, pass, err_count}), 160'(0));
    clear_logs();
    do_start(32'h0000_4000, 16'd2);
    wait_done(5000);
    check_run(32'h4000, 2, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
